// File: rtl/flag_unit.sv
// N/Z/V flag register for the EX stage, with same-cycle forwarding
// of flags being written so a branch resolving in ID sees them without a stall.
module flag_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [3:0]       ex_op,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_ovfl,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_br_valid,
    input  logic [2:0]       id_ccc,
    output logic [2:0]       flags,
    output logic             br_taken,
    output logic             flag_upd
);

    logic n_q, z_q, v_q;
    logic flag_upd_q;

    logic we;
    logic op_arith;
    logic op_zonly;
    logic we_nv;
    logic we_z;
    logic res_n;
    logic res_z;
    logic eff_n, eff_z, eff_v;

    // Reset gates the enable so nothing is forwarded while rst_n is low.
    assign we = rst_n & ex_valid & ~stall & ~flush;

    always_comb begin
        op_arith = 1'b0;
        op_zonly = 1'b0;
        unique case (ex_op)
            4'b0000, 4'b0001:                   op_arith = 1'b1;
            4'b0011, 4'b0100, 4'b0101, 4'b0110: op_zonly = 1'b1;
            default: ;
        endcase
    end

    assign we_nv = we & op_arith;
    assign we_z  = we & (op_arith | op_zonly);
    assign res_n = ex_result[WIDTH-1];
    assign res_z = ~|ex_result;

    assign eff_n = we_nv ? res_n   : n_q;
    assign eff_z = we_z  ? res_z   : z_q;
    assign eff_v = we_nv ? ex_ovfl : v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            v_q        <= 1'b0;
            flag_upd_q <= 1'b0;
        end else begin
            n_q        <= eff_n;
            z_q        <= eff_z;
            v_q        <= eff_v;
            flag_upd_q <= we_z;
        end
    end

    always_comb begin
        br_taken = 1'b0;
        case (id_ccc)
            3'b000: br_taken = ~eff_z;
            3'b001: br_taken = eff_z;
            3'b010: br_taken = ~eff_z & ~eff_n;
            3'b011: br_taken = eff_n;
            3'b100: br_taken = eff_z | ~eff_n;
            3'b101: br_taken = eff_n | eff_z;
            3'b110: br_taken = eff_v;
            3'b111: br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
        br_taken = br_taken & id_br_valid;
    end

    assign flags    = {n_q, z_q, v_q};
    assign flag_upd = flag_upd_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: a flag-mask model checked every cycle plus
// hand-computed literal expectations for each scenario.
module tb_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_op = 4'd0;
    logic [15:0] ex_result = 16'd0;
    logic        ex_ovfl = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_br_valid = 1'b0;
    logic [2:0]  id_ccc = 3'd0;
    logic [2:0]  flags;
    logic        br_taken;
    logic        flag_upd;

    int checks = 0;
    int failures = 0;

    flag_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_result(ex_result), .ex_ovfl(ex_ovfl), .stall(stall), .flush(flush),
        .id_br_valid(id_br_valid), .id_ccc(id_ccc), .flags(flags),
        .br_taken(br_taken), .flag_upd(flag_upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Which of {N,Z,V} an opcode writes.
    function automatic logic [2:0] wmask(input logic [3:0] op);
        case (op)
            4'd0, 4'd1:             return 3'b111;
            4'd3, 4'd4, 4'd5, 4'd6: return 3'b010;
            default:                return 3'b000;
        endcase
    endfunction

    function automatic logic cond(input logic [2:0] ccc, input logic [2:0] f);
        logic n, z, v;
        {n, z, v} = f;
        case (ccc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    logic [2:0] m_flags;
    logic       m_upd;

    function automatic logic [2:0] m_eff();
        logic [2:0] mask;
        logic [2:0] nv;
        mask = (rst_n && ex_valid && !stall && !flush) ? wmask(ex_op) : 3'b000;
        nv   = {ex_result[15], ex_result == 16'd0, ex_ovfl};
        return (mask & nv) | (~mask & m_flags);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags <= 3'b000;
            m_upd   <= 1'b0;
        end else begin
            m_flags <= m_eff();
            m_upd   <= (ex_valid && !stall && !flush && wmask(ex_op) != 3'b000);
        end
    end

    always @(negedge clk) begin
        chk("model_flags", flags, m_flags);
        chk("model_flag_upd", {2'b00, flag_upd}, {2'b00, m_upd});
        chk("model_br_taken", {2'b00, br_taken},
            {2'b00, id_br_valid && cond(id_ccc, m_eff())});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                         input logic ov, input logic st, input logic fl,
                         input logic bv, input logic [2:0] ccc);
        ex_valid = v; ex_op = op; ex_result = res; ex_ovfl = ov;
        stall = st; flush = fl; id_br_valid = bv; id_ccc = ccc;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    // Issue one instruction for a cycle, then check committed flags and pulse.
    task automatic issue(input string name, input logic [3:0] op, input logic [15:0] res,
                         input logic ov, input logic [2:0] exp_f, input logic exp_u);
        drive(1'b1, op, res, ov, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        idle();
        chk({name, "_flags"}, flags, exp_f);
        chk({name, "_upd"}, {2'b00, flag_upd}, {2'b00, exp_u});
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Build flags = 111, then reset mid-cycle.
        issue("add_8000", 4'd0, 16'h8000, 1'b1, 3'b101, 1'b1);
        issue("xor_0", 4'd3, 16'h0000, 1'b0, 3'b111, 1'b1);
        #2;
        drive(1'b1, 4'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
        rst_n = 1'b0;
        #1;
        chk("rst_flags", flags, 3'b000);
        chk("rst_upd", {2'b00, flag_upd}, 3'b000);
        chk("rst_br_eq", {2'b00, br_taken}, 3'b000);
        id_ccc = 3'b111;
        #1;
        chk("rst_br_always", {2'b00, br_taken}, 3'b001);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        issue("add", 4'd0, 16'h8000, 1'b1, 3'b101, 1'b1);
        tick();
        chk("upd_one_cycle", {2'b00, flag_upd}, 3'b000);
        issue("sub", 4'd1, 16'h0000, 1'b0, 3'b010, 1'b1);

        issue("add2", 4'd0, 16'h8000, 1'b1, 3'b101, 1'b1);
        issue("xor_z", 4'd3, 16'h0000, 1'b0, 3'b111, 1'b1);
        issue("sll", 4'd4, 16'h0004, 1'b0, 3'b101, 1'b1);
        issue("paddsb", 4'd7, 16'h0000, 1'b1, 3'b101, 1'b0);
        issue("red", 4'd2, 16'h0000, 1'b1, 3'b101, 1'b0);
        issue("op1010", 4'd10, 16'h0000, 1'b0, 3'b101, 1'b0);

        // Forwarding: registered Z = 0, SUB producing zero with an EQ branch.
        drive(1'b1, 4'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
        #1;
        chk("fwd_eq", {2'b00, br_taken}, 3'b001);
        tick();
        idle();
        chk("fwd_flags", flags, 3'b010);
        issue("add_1", 4'd0, 16'h0001, 1'b0, 3'b000, 1'b1);

        drive(1'b1, 4'd1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001);
        #1;
        chk("stall_br", {2'b00, br_taken}, 3'b000);
        tick();
        idle();
        chk("stall_flags", flags, 3'b000);
        chk("stall_upd", {2'b00, flag_upd}, 3'b000);

        drive(1'b1, 4'd1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'b001);
        #1;
        chk("flush_br", {2'b00, br_taken}, 3'b000);
        tick();
        idle();
        chk("flush_flags", flags, 3'b000);
        chk("flush_upd", {2'b00, flag_upd}, 3'b000);

        // Partial forward: only Z comes from ROR, N from the register.
        issue("add_n", 4'd0, 16'h8000, 1'b0, 3'b100, 1'b1);
        drive(1'b1, 4'd6, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 3'b011);
        #1;
        chk("pfwd_lt", {2'b00, br_taken}, 3'b001);
        id_ccc = 3'b010;
        #1;
        chk("pfwd_gt", {2'b00, br_taken}, 3'b000);
        id_ccc = 3'b110;
        #1;
        chk("pfwd_ov", {2'b00, br_taken}, 3'b000);
        tick();
        idle();
        chk("pfwd_flags", flags, 3'b100);

        // Sweep all flag values and condition codes.
        for (int f = 0; f < 8; f++) begin
            logic [2:0] fv;
            fv = 3'(f);
            issue("sweep_add", 4'd0, fv[2] ? 16'h8000 : 16'h0001, fv[0], {fv[2], 1'b0, fv[0]},
                  1'b1);
            issue("sweep_xor", 4'd3, fv[1] ? 16'h0000 : 16'h0100, 1'b0, fv, 1'b1);
            for (int c = 0; c < 8; c++) begin
                drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'(c));
                #1;
                chk("sweep_br", {2'b00, br_taken}, {2'b00, cond(3'(c), fv)});
                id_br_valid = 1'b0;
                #1;
                chk("sweep_nobr", {2'b00, br_taken}, 3'b000);
            end
            idle();
            tick();
        end

        // Pin the condition function against a few hand-derived values.
        chk("pin_gt_000", {2'b00, cond(3'd2, 3'b000)}, 3'b001);
        chk("pin_ge_100", {2'b00, cond(3'd4, 3'b100)}, 3'b000);
        chk("pin_le_010", {2'b00, cond(3'd5, 3'b010)}, 3'b001);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Sits directly downstream of the 16-bit ALU in the EX stage.
- Consumes the ALU result, the ALU overflow indication and the EX opcode, and maintains the architectural N/Z/V flag register.
- Resolves 3-bit branch conditions for the branch in ID.
- Forwards flags being written in the same cycle, so a branch immediately after a flag-setting instruction sees the new flags without a stall.

Parameters:
- WIDTH, 16, ALU datapath width; Z is computed over all WIDTH bits and N = ex_result[WIDTH-1].

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  EX stage holds a real instruction this cycle
- ex_op  input  4  opcode of EX instruction: 0000 ADD, 0001 SUB, 0010 RED, 0011 XOR, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB, 1xxx memory/control
- ex_result  input  WIDTH  ALU output for the EX instruction
- ex_ovfl  input  1  ALU saturation/overflow detect for ADD/SUB; ignored for all other opcodes
- stall  input  1  pipeline hold; flag register keeps its value
- flush  input  1  EX instruction is squashed; no flag update
- id_br_valid  input  1  a conditional branch is being resolved in ID
- id_ccc  input  3  branch condition code
- flags  output  3  registered {N, Z, V}
- br_taken  output  1  combinational branch decision for the ID branch
- flag_upd  output  1  registered pulse; a flag write committed on the previous edge

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-update):
  - flags = 3'b000.
  - flag_upd = 0.
  - br_taken follows the combinational rule using flags = 000 and no forwarding; it is 1 only for ccc 000/010/100/111 with id_br_valid = 1.
- Write enable: we = ex_valid & ~stall & ~flush. flush has priority over ex_valid; stall has priority over everything except reset.
- Flag update by opcode when we = 1, registered at the next rising edge:
  - ADD, SUB: N = ex_result[WIDTH-1]; Z = (ex_result == 0); V = ex_ovfl.
  - XOR, SLL, SRA, ROR: Z = (ex_result == 0); N and V hold.
  - RED, PADDSB, 1xxx: no flag change, and flag_upd stays 0.
- flag_upd = 1 for exactly one cycle after an edge on which any flag bit was write-enabled. This holds even if the written value equals the old value.
- Forwarding:
  - eff_{N,Z,V} per bit = the next-state value being written this cycle if that bit is write-enabled, else the registered value.
  - XOR/SLL/SRA/ROR in EX forward only Z; N and V come from the register.
  - A stalled or flushed EX instruction never forwards.
- br_taken = id_br_valid & cond(id_ccc, eff flags). Latency 0 (combinational). br_taken = 0 whenever id_br_valid = 0. Conditions:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | !N
  - 101 LE: N | Z
  - 110 OV: V
  - 111 always: 1
- Simultaneous events:
  - Flag-setting EX instruction plus ID branch in the same cycle: the branch uses the forwarded values.
  - stall with id_br_valid: br_taken is still evaluated from the registered flags.
  - Consecutive flag-setting instructions: each edge commits the newest result; there is no queueing.
- Width rules:
  - Z is the NOR of all WIDTH bits.
  - For PADDSB, ex_ovfl is ignored even if asserted.
- No X propagation: ex_op values 1000–1111 are legal and behave as no-update.

Test Plan:
- Reset then idle: assert rst_n = 0 mid-cycle after flags = 111 -> flags = 000 immediately, flag_upd = 0; id_br_valid = 1, ccc = 001 -> br_taken = 0; ccc = 111 -> br_taken = 1.
- ADD update: ex_valid = 1, op = 0000, result = 16'h8000, ex_ovfl = 1 -> next cycle flags = {1,0,1}, flag_upd = 1 for one cycle; then SUB, result = 0, ovfl = 0 -> flags = {0,1,0}.
- Partial update: flags = {1,0,1}; XOR with result 0 -> flags = {1,1,1}. Then SLL result 16'h0004 -> {1,0,1}. Then PADDSB/RED/1010 with any result -> flags unchanged, flag_upd = 0.
- Forwarding:
  - Registered Z = 0; SUB in EX with result 0 while ID branch ccc = 001 -> br_taken = 1 in the same cycle.
  - Same stimulus with stall = 1 -> br_taken = 0 and flags unchanged.
  - Same stimulus with flush = 1 -> br_taken = 0 and flags unchanged.
- Partial forward: registered {N,Z,V} = {1,0,0}; ROR result 16'h0001 in EX, ccc = 011 -> br_taken = 1 (N taken from register). ccc = 010 -> br_taken = 0.
- Condition sweep: for all 8 flag values × 8 ccc values, with id_br_valid toggled, br_taken matches the condition rules above; id_br_valid = 0 -> br_taken = 0 in all 64 cases.
